// File: rtl/line_window_gen_if.sv
// Handshake bundle for line_window_gen: raster pixel input stream and registered 3x3 window output.
// master = pixel source / window consumer side, slave = line_window_gen side.
interface line_window_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  pix_valid;
  logic                  pix_ready;
  logic [DATA_WIDTH-1:0] pix_in;
  logic                  win_valid;
  logic                  win_ready;
  logic [DATA_WIDTH-1:0] line0_data0, line0_data1, line0_data2;
  logic [DATA_WIDTH-1:0] line1_data0, line1_data1, line1_data2;
  logic [DATA_WIDTH-1:0] line2_data0, line2_data1, line2_data2;
  logic [3:0]            corner_type;

  modport master (
    output pix_valid, pix_in, win_ready,
    input  pix_ready, win_valid, corner_type,
    input  line0_data0, line0_data1, line0_data2,
    input  line1_data0, line1_data1, line1_data2,
    input  line2_data0, line2_data1, line2_data2
  );

  modport slave (
    input  pix_valid, pix_in, win_ready,
    output pix_ready, win_valid, corner_type,
    output line0_data0, line0_data1, line0_data2,
    output line1_data0, line1_data1, line1_data2,
    output line2_data0, line2_data1, line2_data2
  );
endinterface

// File: rtl/line_window_gen.sv
// Raster pixel stream -> registered 3x3 neighbourhood window, off-image taps forced to zero.
// Define LINE_WINDOW_GEN_FRAME_DONE_EN to add the frame_done / frame_cnt outputs.
module line_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480
) (
  input  logic             clk,
  input  logic             rst,
  line_window_gen_if.slave bus
`ifdef LINE_WINDOW_GEN_FRAME_DONE_EN
  ,
  output logic             frame_done,
  output logic [15:0]      frame_cnt
`endif
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  state_t state;

  // col/row index the incoming pixel; ccol/crow index the centre of the next window emitted
  logic [CW-1:0] col, ccol;
  logic [RW-1:0] row, crow;

  logic [DATA_WIDTH-1:0] lb0 [IMG_W];
  logic [DATA_WIDTH-1:0] lb1 [IMG_W];
  logic [DATA_WIDTH-1:0] win  [3][3];
  logic [DATA_WIDTH-1:0] nwin [3][3];
  logic [DATA_WIDTH-1:0] ntap [3][3];
  logic [DATA_WIDTH-1:0] tap  [3][3];
  logic [DATA_WIDTH-1:0] new_col [3];

  logic       win_valid_q;
  logic [3:0] corner_q, ncorner;
  logic       pix_ready, slot_free, accept, flush_step, adv, emit;
  logic       edge_l, edge_r, edge_t, edge_b, centre_last;

  always_comb begin
    slot_free = !win_valid_q || bus.win_ready;
    case (state)
      IDLE, FILL: pix_ready = 1'b1;
      RUN:        pix_ready = slot_free;
      default:    pix_ready = 1'b0;
    endcase
    accept     = bus.pix_valid && pix_ready;
    flush_step = (state == FLUSH) && slot_free;
    adv        = accept || flush_step;
    emit       = ((state == RUN) && accept) || flush_step;

    edge_l      = (ccol == '0);
    edge_r      = (ccol == COL_LAST);
    edge_t      = (crow == '0);
    edge_b      = (crow == ROW_LAST);
    centre_last = edge_r && edge_b;

    new_col[0] = lb1[col];
    new_col[1] = lb0[col];
    new_col[2] = (state == FLUSH) ? '0 : bus.pix_in;
    for (int unsigned r = 0; r < 3; r++) begin
      nwin[r][0] = win[r][1];
      nwin[r][1] = win[r][2];
      nwin[r][2] = new_col[r];
    end

    // Masking also hides the columns that wrapped in from the neighbouring row.
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        if ((c == 0 && edge_l) || (c == 2 && edge_r) || (r == 0 && edge_t) || (r == 2 && edge_b))
          ntap[r][c] = '0;
        else
          ntap[r][c] = nwin[r][c];
      end
    end

    if (edge_t && edge_l)      ncorner = 4'd6;
    else if (edge_t && edge_r) ncorner = 4'd5;
    else if (edge_b && edge_r) ncorner = 4'd1;
    else if (edge_b && edge_l) ncorner = 4'd2;
    else if (edge_l)           ncorner = 4'd4;
    else if (edge_r)           ncorner = 4'd3;
    else if (edge_t || edge_b) ncorner = 4'd7;
    else                       ncorner = 4'd8;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      lb1[col] <= lb0[col];
      lb0[col] <= new_col[2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      ccol        <= '0;
      crow        <= '0;
      win_valid_q <= 1'b0;
      corner_q    <= '0;
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          win[r][c] <= '0;
          tap[r][c] <= '0;
        end
      end
    end else begin
      if (adv) begin
        win <= nwin;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (emit) begin
        tap         <= ntap;
        corner_q    <= ncorner;
        win_valid_q <= 1'b1;
        if (ccol == COL_LAST) begin
          ccol <= '0;
          crow <= (crow == ROW_LAST) ? '0 : crow + 1'b1;
        end else begin
          ccol <= ccol + 1'b1;
        end
      end else if (win_valid_q && bus.win_ready) begin
        win_valid_q <= 1'b0;
        corner_q    <= '0;
      end

      case (state)
        IDLE:  if (accept) state <= FILL;
        FILL:  if (accept && row == RW'(1) && col == '0) state <= RUN;
        RUN:   if (accept && row == ROW_LAST && col == COL_LAST) state <= FLUSH;
        FLUSH: begin
          // Flush pixels walk col past the frame; rewind so the next frame starts at 0.
          if (flush_step && centre_last) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pix_ready   = pix_ready;
  assign bus.win_valid   = win_valid_q;
  assign bus.corner_type = corner_q;
  assign bus.line0_data0 = tap[0][0];
  assign bus.line0_data1 = tap[0][1];
  assign bus.line0_data2 = tap[0][2];
  assign bus.line1_data0 = tap[1][0];
  assign bus.line1_data1 = tap[1][1];
  assign bus.line1_data2 = tap[1][2];
  assign bus.line2_data0 = tap[2][0];
  assign bus.line2_data1 = tap[2][1];
  assign bus.line2_data2 = tap[2][2];

`ifdef LINE_WINDOW_GEN_FRAME_DONE_EN
  logic last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (emit)                             last_q <= centre_last;
      else if (win_valid_q && bus.win_ready) last_q <= 1'b0;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign frame_done = win_valid_q && bus.win_ready && last_q;
`endif
endmodule

// File: tb/tb_line_window_gen.sv
// Bench for line_window_gen (IMG_W=4, IMG_H=3): frame-level window model, directed and random frames.
module tb_line_window_gen;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct packed {
    logic [3:0]      ct;
    logic [8:0][7:0] tp;
  } win_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_window_gen_if #(.DATA_WIDTH(8)) bus ();

`ifdef LINE_WINDOW_GEN_FRAME_DONE_EN
  logic        frame_done;
  logic [15:0] frame_cnt;
  int          done_pulses = 0;
`endif

  line_window_gen #(.DATA_WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LINE_WINDOW_GEN_FRAME_DONE_EN
    ,
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
`endif
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   rdy_mode = 0;
  int   stall_left = 0;
  int   last_acc_edge = 0;
  int   first_valid_cyc = -1;
  logic [7:0] frame_img [N];
  win_t exp_q [$];
  win_t got_q [$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic win_t sample();
    win_t s;
    s.ct = bus.corner_type;
    s.tp = {bus.line2_data2, bus.line2_data1, bus.line2_data0,
            bus.line1_data2, bus.line1_data1, bus.line1_data0,
            bus.line0_data2, bus.line0_data1, bus.line0_data0};
    return s;
  endfunction

  function automatic win_t mkwin(input logic [3:0] ct, input logic [7:0] a, b, c, d, e, f, g, h, i);
    win_t w;
    w.ct = ct;
    w.tp = {i, h, g, f, e, d, c, b, a};
    return w;
  endfunction

  function automatic logic [3:0] corner_of(input int r, input int c);
    bit top = (r == 0), bot = (r == H - 1), lft = (c == 0), rgt = (c == W - 1);
    if (top && lft) return 4'd6;
    if (top && rgt) return 4'd5;
    if (bot && rgt) return 4'd1;
    if (bot && lft) return 4'd2;
    if (lft)        return 4'd4;
    if (rgt)        return 4'd3;
    if (top || bot) return 4'd7;
    return 4'd8;
  endfunction

  // Every centre of the image, raster order, neighbours outside the image read as zero.
  function automatic void push_frame();
    win_t w;
    int rr, cc;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        w.ct = corner_of(r, c);
        for (int dr = 0; dr < 3; dr++) begin
          for (int dc = 0; dc < 3; dc++) begin
            rr = r + dr - 1;
            cc = c + dc - 1;
            w.tp[dr*3+dc] = (rr >= 0 && rr < H && cc >= 0 && cc < W) ? frame_img[rr*W+cc] : 8'd0;
          end
        end
        exp_q.push_back(w);
      end
    end
  endfunction

  // Compare process: every handshaked window against the model, every stalled cycle for stability.
  win_t held;
  bit   stall_prev = 0;
  always @(negedge clk) begin
    win_t cur, e;
    cur = sample();
    if (rst) begin
      stall_prev = 0;
`ifdef LINE_WINDOW_GEN_FRAME_DONE_EN
      done_pulses = 0;
`endif
    end else begin
      if (stall_prev) check("hold_stable", {3'b0, bus.win_valid, cur}, {3'b0, 1'b1, held});
      if (bus.win_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.win_valid && bus.win_ready) begin
        check("window_expected", 80'(exp_q.size() > 0), 80'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("window", 80'(cur), 80'(e));
        end
        got_q.push_back(cur);
      end
`ifdef LINE_WINDOW_GEN_FRAME_DONE_EN
      if (frame_done) done_pulses++;
`endif
      stall_prev = bus.win_valid && !bus.win_ready;
      held = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (stall_left > 0) begin
      bus.win_ready = 1'b0;
      stall_left--;
    end else if (rdy_mode == 1) bus.win_ready = ($urandom_range(0, 3) != 0);
    else bus.win_ready = 1'b1;
  endtask

  task automatic send(input logic [7:0] v, input int gap);
    int n;
    while (gap > 0 && $urandom_range(0, 99) < gap) begin
      bus.pix_valid = 1'b0;
      tick();
    end
    bus.pix_valid = 1'b1;
    bus.pix_in    = v;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.pix_ready) break;
      tick();
      n++;
      if (n > 500) begin
        check("send_timeout", 80'(bus.pix_ready), 80'd1);
        break;
      end
    end
    last_acc_edge = cyc + 1;
    tick();
    bus.pix_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 600; i++) begin
      tick();
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.win_valid) break;
    end
    check({tag, "_drain"}, 80'(exp_q.size()), 80'd0);
    check({tag, "_corner_idle"}, 80'(bus.corner_type), 80'd0);
    tick();
  endtask

  task automatic literal_checks(input string tag);
    check({tag, "_count"},  80'(got_q.size()), 80'd12);
    check({tag, "_first"},  80'(got_q[0]),  80'(mkwin(4'd6, 0, 0, 0, 0, 1, 2, 0, 5, 6)));
    check({tag, "_centre"}, 80'(got_q[5]),  80'(mkwin(4'd8, 1, 2, 3, 5, 6, 7, 9, 10, 11)));
    check({tag, "_last"},   80'(got_q[11]), 80'(mkwin(4'd1, 7, 8, 0, 11, 12, 0, 0, 0, 0)));
  endtask

  initial begin
    int n, p6_edge;
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    bus.win_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_win_valid", 80'(bus.win_valid), 80'd0);
    check("rst_corner",    80'(bus.corner_type), 80'd0);
    check("rst_taps",      80'(sample().tp), 80'd0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("pix_ready_after_rst", 80'(bus.pix_ready), 80'd1);
    tick();

    // Frame A: pixels 1..12, downstream always ready
    first_valid_cyc = -1;
    got_q.delete();
    for (int i = 0; i < N; i++) frame_img[i] = 8'(i + 1);
    push_frame();
    p6_edge = 0;
    for (int i = 0; i < N; i++) begin
      send(frame_img[i], 0);
      if (i == 5) p6_edge = last_acc_edge;
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.pix_ready || n > 50) break;
      n++;
      tick();
    end
    check("flush_ready_low_cycles", 80'(n), 80'(W + 1));
    drain("frame_a");
    check("first_window_timing", 80'(first_valid_cyc), 80'(p6_edge));
    literal_checks("frame_a");

    // Frame B: downstream stalls for 5 cycles mid-RUN
    got_q.delete();
    for (int i = 0; i < N; i++) frame_img[i] = 8'(20 + 3 * i);
    push_frame();
    for (int i = 0; i < 8; i++) send(frame_img[i], 0);
    bus.win_ready = 1'b0;
    stall_left    = 4;
    bus.pix_valid = 1'b1;
    bus.pix_in    = frame_img[8];
    repeat (5) begin
      @(negedge clk);
      check("stall_pix_ready", 80'(bus.pix_ready), 80'd0);
      tick();
    end
    for (int i = 8; i < N; i++) send(frame_img[i], 0);
    drain("frame_b");
    check("frame_b_count", 80'(got_q.size()), 80'd12);

    // Frame C: reset after pixel 7 with a pixel offered during reset, then a clean frame
    got_q.delete();
    for (int i = 0; i < N; i++) frame_img[i] = 8'(i + 1);
    push_frame();
    for (int i = 0; i < 7; i++) send(frame_img[i], 0);
    rst = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_in    = 8'd99;
    tick();
    tick();
    exp_q.delete();
    got_q.delete();
    @(negedge clk);
    check("rst_mid_win_valid", 80'(bus.win_valid), 80'd0);
    tick();
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    tick();
    push_frame();
    for (int i = 0; i < N; i++) send(frame_img[i], 0);
    drain("frame_c");
    literal_checks("frame_c");

    // Four random back-to-back frames with random bubbles and backpressure
    rdy_mode = 1;
    got_q.delete();
    repeat (4) begin
      for (int i = 0; i < N; i++) frame_img[i] = 8'($urandom);
      push_frame();
      for (int i = 0; i < N; i++) send(frame_img[i], 30);
    end
    drain("random");
    check("random_count", 80'(got_q.size()), 80'(4 * N));
    rdy_mode = 0;

`ifdef LINE_WINDOW_GEN_FRAME_DONE_EN
    check("frame_done_pulses", 80'(done_pulses), 80'd5);
    check("frame_cnt",         80'(frame_cnt),   80'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
